// File: rtl/merge_net_scheduler.sv
// rtl/merge_net_scheduler.sv - round-robin issue of requester vectors into one shared merge network, tagged result FIFO
// Optional per-requester statistics outputs are built when SCHED_STATS_EN is defined.
module merge_net_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int LOG_INPUT   = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int NET_LATENCY = 10,
    parameter int FIFO_DEPTH  = 16,
    localparam int VEC_W = DATA_WIDTH * (2 ** LOG_INPUT),
    localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*VEC_W-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [VEC_W-1:0]         net_x,
    output logic                     net_x_valid,
    input  logic [VEC_W-1:0]         net_y,
    input  logic                     net_y_valid,
    output logic [VEC_W-1:0]         res_data,
    output logic [IDW-1:0]           res_id,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     tag_err
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_stall,
    output logic [NUM_REQ*16-1:0]    stat_grant
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(NET_LATENCY + 1);

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;
    logic [VEC_W-1:0] grant_data;
    logic             transfer;
    logic             credit_ok;
    logic [CW:0]      credit_sum;

    logic [CW-1:0]    inflight;
    logic [CW-1:0]    fifo_count;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [VEC_W-1:0] mem_data [FIFO_DEPTH];
    logic [IDW-1:0]   mem_id   [FIFO_DEPTH];

    logic [IDW-1:0]         issue_id;
    logic [NET_LATENCY-1:0] tag_v;
    logic [IDW-1:0]         tag_id [NET_LATENCY];
    logic [GW-1:0]          guard_cnt;
    logic                   ignore;
    logic                   y_ok;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;

    // Every issued vector reserves a FIFO slot until it is popped, so the FIFO cannot overflow.
    assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count} + (CW+1)'(1);
    assign credit_ok  = credit_sum <= (CW+1)'(FIFO_DEPTH);
    assign transfer   = grant_any & credit_ok & rst;

    always_comb begin
        logic [IDW-1:0] cand;
        req_ready  = '0;
        grant_id   = '0;
        grant_any  = 1'b0;
        grant_data = '0;
        cand       = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
            cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + IDW'(1);
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_id == IDW'(r)) grant_data = req_data[r*VEC_W +: VEC_W];
        end
        req_ready[grant_id] = transfer;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr      <= '0;
            net_x       <= '0;
            net_x_valid <= 1'b0;
            issue_id    <= '0;
        end else begin
            net_x_valid <= transfer;
            if (transfer) begin
                net_x    <= grant_data;
                issue_id <= grant_id;
                rr_ptr   <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
            end
        end
    end

    // Results still draining from before a reset arrive inside the guard window and are dropped.
    assign ignore    = guard_cnt < GW'(NET_LATENCY);
    assign y_ok      = net_y_valid & ~ignore;
    assign fifo_full = fifo_count == CW'(FIFO_DEPTH);
    assign push      = y_ok & ~fifo_full;
    assign pop       = res_valid & res_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_v     <= '0;
            guard_cnt <= '0;
            tag_err   <= 1'b0;
            inflight  <= '0;
            for (int s = 0; s < NET_LATENCY; s++) tag_id[s] <= '0;
        end else begin
            tag_v[0]  <= net_x_valid;
            tag_id[0] <= issue_id;
            for (int s = 1; s < NET_LATENCY; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            if (ignore) guard_cnt <= guard_cnt + GW'(1);
            if ((~ignore & (net_y_valid != tag_v[NET_LATENCY-1])) | (y_ok & fifo_full))
                tag_err <= 1'b1;
            inflight <= inflight + CW'(transfer) - CW'(y_ok & (inflight != '0));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= net_y;
            mem_id[wr_ptr]   <= tag_id[NET_LATENCY-1];
        end
    end

    assign res_valid = fifo_count != '0;
    assign res_data  = mem_data[rd_ptr];
    assign res_id    = mem_id[rd_ptr];

`ifdef SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_issued <= '0;
            stat_stall  <= '0;
            stat_grant  <= '0;
        end else begin
            if (transfer && stat_issued != '1) stat_issued <= stat_issued + 32'd1;
            if (|req_valid && !transfer && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (transfer && grant_id == IDW'(r) && stat_grant[r*16 +: 16] != 16'hFFFF)
                    stat_grant[r*16 +: 16] <= stat_grant[r*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_merge_net_scheduler.sv
// tb/tb_merge_net_scheduler.sv - directed bench for merge_net_scheduler with a byte-sorting network model
module tb_merge_net_scheduler;

    localparam int NR  = 4;
    localparam int L   = 10;
    localparam int VW  = 128;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*VW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [VW-1:0]     net_x;
    logic              net_x_valid;
    logic [VW-1:0]     net_y;
    logic              net_y_valid;
    logic [VW-1:0]     res_data;
    logic [IDW-1:0]    res_id;
    logic              res_valid;
    logic              res_ready;
    logic              tag_err;
`ifdef SCHED_STATS_EN
    logic [31:0]       stat_issued;
    logic [31:0]       stat_stall;
    logic [NR*16-1:0]  stat_grant;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    merge_net_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .net_x       (net_x),
        .net_x_valid (net_x_valid),
        .net_y       (net_y),
        .net_y_valid (net_y_valid),
        .res_data    (res_data),
        .res_id      (res_id),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .tag_err     (tag_err)
`ifdef SCHED_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall),
        .stat_grant  (stat_grant)
`endif
    );

    always #5 clk = ~clk;

    // Network model: sorts bytes so the largest lands in byte 0, fixed latency L, never reset.
    function automatic logic [VW-1:0] sort_desc(input logic [VW-1:0] v);
        logic [7:0] b [16];
        logic [7:0] t;
        logic [VW-1:0] o;
        for (int i = 0; i < 16; i++) b[i] = v[i*8 +: 8];
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 15 - i; j++)
                if (b[j] < b[j+1]) begin t = b[j]; b[j] = b[j+1]; b[j+1] = t; end
        o = '0;
        for (int i = 0; i < 16; i++) o[i*8 +: 8] = b[i];
        return o;
    endfunction

    logic [VW-1:0] pipe_d [L];
    logic [L-1:0]  pipe_v;
    logic          inject;

    initial begin
        pipe_v = '0;
        for (int s = 0; s < L; s++) pipe_d[s] = '0;
    end

    always @(posedge clk) begin
        pipe_v    <= {pipe_v[L-2:0], net_x_valid};
        pipe_d[0] <= sort_desc(net_x);
        for (int s = 1; s < L; s++) pipe_d[s] <= pipe_d[s-1];
    end

    assign net_y       = pipe_d[L-1];
    assign net_y_valid = pipe_v[L-1] | inject;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int cnt;
        int k;
        logic [IDW-1:0] exp_ids [5];
        logic [7:0] fill;
        exp_ids = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst = 1'b0; req_valid = '0; req_data = '0; res_ready = 1'b1; inject = 1'b0;

        // 1: reset with every requester asking
        req_valid = '1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("rst_req_ready", VW'(req_ready), '0);
            chk("rst_net_x_valid", VW'(net_x_valid), '0);
            chk("rst_res_valid", VW'(res_valid), '0);
            chk("rst_tag_err", VW'(tag_err), '0);
        end
        tick();
        rst = 1'b1; req_valid = '0;

        // 2: single request from requester 2, latency and sorted payload
        tick();
        req_valid = 4'b0100;
        req_data[2*VW +: VW] = 128'h0F0E0D0C0B0A09080706050403020100;
        @(negedge clk);
        chk("t2_grant", VW'(req_ready), VW'(4'b0100));
        tick();
        req_valid = '0;
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (res_valid) break;
        end
        chk("t2_latency", VW'(lat), VW'(12));
        chk("t2_res_id", VW'(res_id), VW'(2));
        chk("t2_res_data", res_data, 128'h000102030405060708090A0B0C0D0E0F);

        // 3: all four requesting, round robin from pointer 0
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req_valid = '1;
        for (int r = 0; r < NR; r++) begin
            fill = 8'(17 * (r + 1));
            req_data[r*VW +: VW] = {16{fill}};
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_grant", VW'(req_ready), VW'(4'b0001 << (i % 4)));
            tick();
        end
        req_valid = '0;
        k = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (res_valid && k < 5) begin
                fill = 8'(17 * (int'(exp_ids[k]) + 1));
                chk("t3_res_id", VW'(res_id), VW'(exp_ids[k]));
                chk("t3_res_data", res_data, {16{fill}});
                k++;
            end
        end
        chk("t3_result_count", VW'(k), VW'(5));

        // 4: consumer stalled, credit limits issue to FIFO_DEPTH vectors
        tick();
        res_ready = 1'b0;
        req_valid = '1;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) cnt++;
            tick();
        end
        @(negedge clk);
        chk("t4_transfers", VW'(cnt), VW'(16));
        chk("t4_stalled", VW'(req_ready), '0);
        chk("t4_res_valid", VW'(res_valid), VW'(1));
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        chk("t4_before_pop", VW'(req_ready), '0);
        tick();
        @(negedge clk);
        chk("t4_resume", VW'(req_ready != '0), VW'(1));
        tick();
        req_valid = '0;
        for (int c = 0; c < 40; c++) tick();
        @(negedge clk);
        chk("t4_drained", VW'(res_valid), '0);
        chk("t4_tag_err", VW'(tag_err), '0);

        // 5: spurious network result
        tick();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        @(negedge clk);
        chk("t5_tag_err", VW'(tag_err), VW'(1));
        chk("t5_pushed", VW'(res_valid), VW'(1));
        for (int c = 0; c < 5; c++) tick();
        @(negedge clk);
        chk("t5_tag_err_held", VW'(tag_err), VW'(1));
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_tag_err_cleared", VW'(tag_err), '0);
        chk("t5_fifo_cleared", VW'(res_valid), '0);

        // 6: reset with five vectors in flight
        tick();
        req_valid = '1;
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b0;
        req_valid = '0;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            chk("t6_no_stale", VW'(res_valid), '0);
            chk("t6_no_tag_err", VW'(tag_err), '0);
            tick();
        end
        req_valid = '1;
        @(negedge clk);
        chk("t6_ptr_zero", VW'(req_ready), VW'(4'b0001));
        tick();
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
